ascon_core_arbiter: RTL and testbench
=====================================

# ascon_core_arbiter

Shares one ASCON initialisation core (12-round permutation, single start/done interface, runtime-loadable S-box LUT) between `NREQ` independent requesters and one S-box configuration port. Requests are granted round-robin, each job is sequenced through the core, and the permuted state is returned on a valid/ready response channel tagged with the requester ID. The block sits between the bus-side request sources and the core instance, and is the only driver of the core's `start_i`, `state_i` and S-box update inputs.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 20: maximum cycles in WAIT before a job is aborted.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid_i`  in  NREQ  per-requester job request.
- `req_state_i`  in  NREQ x state_t (5x64)  per-requester input state.
- `req_ready_o`  out  NREQ  one-hot accept pulse.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumer ready.
- `rsp_id_o`  out  $clog2(NREQ)  requester index of the response.
- `rsp_state_o`  out  state_t  permuted state.
- `rsp_err_o`  out  1  job aborted by timeout; `rsp_state_o` is all-zero.
- `cfg_valid_i`, `cfg_addr_i` (5), `cfg_data_i` (21)  in  S-box LUT write request.
- `cfg_ready_o`  out  1  LUT write accepted this cycle.
- `core_start_o`  out  1  core start pulse.
- `core_state_o`  out  state_t  core input state.
- `core_upd_sbox_o`, `core_sbox_addr_o` (5), `core_sbox_data_o` (21)  out  LUT write to core.
- `core_busy_i`  in  1  core busy.
- `core_state_i`  in  state_t  core output state.
- `core_intr_i`  in  1  core one-cycle done pulse.

## Operation
- FSM states: IDLE, START, WAIT, RESP.
- IDLE: `cfg_ready_o = 1`. If `cfg_valid_i`, drive `core_upd_sbox_o = 1` with addr/data combinationally; stay IDLE. Config has strict priority over jobs; no grant in a cycle with `cfg_valid_i = 1`.
- IDLE, no cfg, any `req_valid_i`: round-robin grant starting from index after `last_grant`; assert `req_ready_o[g]` (combinational, same cycle); latch `req_state_i[g]` into `job_state`, `g` into `job_id`; `last_grant <= g`; go START.
- START: `core_start_o = 1`, `core_state_o = job_state`; go WAIT, clear watchdog counter.
- WAIT: increment watchdog counter. On `core_intr_i`: capture `core_state_i` into response register, `rsp_err_o <= 0`, go RESP. If counter reaches `TIMEOUT` first: response state zero, `rsp_err_o <= 1`, go RESP.
- RESP: `rsp_valid_o = 1`, outputs stable until `rsp_ready_i`; on handshake go IDLE.
- `cfg_ready_o = 0` and `req_ready_o = 0` in START/WAIT/RESP; LUT is never written while the core runs.
- `core_state_o` driven with `job_state` in all states; only sampled by the core with `core_start_o`.
- `core_busy_i` is not used for sequencing; only for the assertion: `core_busy_i = 0` whenever FSM is IDLE.

## Timing
- Reset values: all outputs 0, FSM IDLE, `last_grant = NREQ-1` (requester 0 wins first), counter 0.
- Cycle 0: accept (`req_valid_i & req_ready_o`). Cycle 1: `core_start_o`. Core busy cycles 2-13, `core_intr_i` cycle 14. `rsp_valid_o` from cycle 15.
- Back-to-back: response handshake in cycle N -> IDLE in N+1 -> next accept earliest N+1; minimum job interval 16 cycles.
- Config write: 1 cycle, no latency beyond combinational pass-through.
- Simultaneous `core_intr_i` and timeout in the same cycle: intr wins, `rsp_err_o = 0`.
- Requests withdrawn before grant: no effect; requests not granted are not latched.
- Async reset mid-job: everything returns to reset values immediately; the in-flight job is dropped, no response.

## Structure
- `ascon_pkg`: `state_t`, `ASCON_ROUNDS = 12`, `SBOX_ADDR_W = 5`, `SBOX_DATA_W = 21`, arbiter FSM enum.
- Sub-module `rr_arbiter` (`NREQ`-wide round-robin grant from request vector and last-grant pointer, combinational, one-hot + index outputs).

## Test plan
- Single job: req 2 valid with state 0x..80400c0600000000 IV vector -> `req_ready_o = 4'b0100` cycle 0, `core_start_o` cycle 1, `rsp_valid_o` cycle 15, `rsp_id_o = 2`, state equals golden 12-round permutation.
- Fairness: all 4 requesters valid continuously, `rsp_ready_i = 1` -> grant order 0,1,2,3,0; each interval 16 cycles.
- Config priority: `cfg_valid_i` and `req_valid_i[0]` both high in IDLE for 3 cycles -> 3 LUT writes forwarded, grant in cycle 3; `cfg_ready_o = 0` throughout job.
- Backpressure: `rsp_ready_i = 0` for 10 cycles after response -> `rsp_*` stable, no new grant, no LUT write accepted.
- Timeout: core model suppresses `core_intr_i` -> `rsp_valid_o` with `rsp_err_o = 1`, zero state, `TIMEOUT + 2` cycles after start.
- Reset at cycle 7 of a job -> all outputs 0 next cycle; next request from 0 is granted first.

Source files
------------

// File: rtl/ascon_pkg.sv
// Shared types and constants for the ASCON core arbiter slice.
// Holds the permutation state type, S-box LUT port widths and arbiter FSM encoding.
package ascon_pkg;

   localparam int ASCON_ROUNDS = 12;
   localparam int SBOX_ADDR_W  = 5;
   localparam int SBOX_DATA_W  = 21;
   localparam int STATE_WORDS  = 5;

   // Word 0 is x0 (the IV word), word 4 is x4.
   typedef logic [STATE_WORDS-1:0][63:0] state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last grant and wraps.
// Outputs a one-hot grant, its index, and a flag that any request was present.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx,
   output logic            any
);

   logic [IDW-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IDW'((int'(last) + k) % NREQ);
         if (!any && req[cand]) begin
            any         = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ascon_core_arbiter.sv
// Shares one ASCON permutation core between NREQ requesters and the S-box LUT config port.
// Jobs are granted round-robin, run to core done or watchdog abort, and returned tagged by requester.
module ascon_core_arbiter
   import ascon_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 20
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid_i,
   input  state_t [NREQ-1:0]       req_state_i,
   output logic [NREQ-1:0]         req_ready_o,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [$clog2(NREQ)-1:0] rsp_id_o,
   output state_t                  rsp_state_o,
   output logic                    rsp_err_o,
   input  logic                    cfg_valid_i,
   input  logic [SBOX_ADDR_W-1:0]  cfg_addr_i,
   input  logic [SBOX_DATA_W-1:0]  cfg_data_i,
   output logic                    cfg_ready_o,
   output logic                    core_start_o,
   output state_t                  core_state_o,
   output logic                    core_upd_sbox_o,
   output logic [SBOX_ADDR_W-1:0]  core_sbox_addr_o,
   output logic [SBOX_DATA_W-1:0]  core_sbox_data_o,
   input  logic                    core_busy_i,
   input  state_t                  core_state_i,
   input  logic                    core_intr_i
);

   localparam int IDW  = $clog2(NREQ);
   localparam int CNTW = $clog2(TIMEOUT + 1);
   localparam logic [CNTW-1:0] WDOG_MAX = CNTW'(TIMEOUT);

   arb_state_e     state_q, state_d;
   state_t         job_state_q;
   state_t         rsp_state_q;
   logic [IDW-1:0] job_id_q;
   logic [IDW-1:0] last_grant_q;
   logic [CNTW-1:0] wdog_q;
   logic           rsp_err_q;
   logic           out_en_q;

   logic [NREQ-1:0] gnt_onehot;
   logic [IDW-1:0]  gnt_idx;
   logic            gnt_any;
   logic            accept;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr (
      .req       (req_valid_i),
      .last      (last_grant_q),
      .grant     (gnt_onehot),
      .grant_idx (gnt_idx),
      .any       (gnt_any)
   );

   // out_en_q keeps every handshake output low while reset is held and for the first edge after it.
   assign accept = (state_q == IDLE) && out_en_q && !cfg_valid_i && gnt_any;

   always_comb begin
      state_d          = state_q;
      req_ready_o      = '0;
      cfg_ready_o      = 1'b0;
      core_start_o     = 1'b0;
      core_upd_sbox_o  = 1'b0;
      core_sbox_addr_o = '0;
      core_sbox_data_o = '0;
      rsp_valid_o      = 1'b0;
      case (state_q)
         IDLE: begin
            if (out_en_q) begin
               cfg_ready_o = 1'b1;
               if (cfg_valid_i) begin
                  core_upd_sbox_o  = 1'b1;
                  core_sbox_addr_o = cfg_addr_i;
                  core_sbox_data_o = cfg_data_i;
               end else if (gnt_any) begin
                  req_ready_o = gnt_onehot;
                  state_d     = START;
               end
            end
         end
         START: begin
            core_start_o = 1'b1;
            state_d      = WAIT;
         end
         WAIT: begin
            if (core_intr_i || (wdog_q == WDOG_MAX)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         job_state_q  <= '0;
         rsp_state_q  <= '0;
         job_id_q     <= '0;
         last_grant_q <= IDW'(NREQ - 1);
         wdog_q       <= '0;
         rsp_err_q    <= 1'b0;
         out_en_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         out_en_q <= 1'b1;
         if (accept) begin
            job_state_q  <= req_state_i[gnt_idx];
            job_id_q     <= gnt_idx;
            last_grant_q <= gnt_idx;
         end
         if (state_q == START) begin
            wdog_q <= '0;
         end
         // A done pulse in the same cycle as the watchdog limit still returns real data.
         if (state_q == WAIT) begin
            if (core_intr_i) begin
               rsp_state_q <= core_state_i;
               rsp_err_q   <= 1'b0;
            end else if (wdog_q == WDOG_MAX) begin
               rsp_state_q <= '0;
               rsp_err_q   <= 1'b1;
            end else begin
               wdog_q <= wdog_q + 1'b1;
            end
         end
      end
   end

   assign rsp_id_o     = job_id_q;
   assign rsp_state_o  = rsp_state_q;
   assign rsp_err_o    = rsp_err_q;
   assign core_state_o = job_state_q;

   a_core_idle_when_arb_idle : assert property (
      @(posedge clk) disable iff (!rst_n) (state_q == IDLE) |-> !core_busy_i
   );

endmodule

// File: tb/tb_ascon_core_arbiter.sv
// Bench for ascon_core_arbiter: behavioural core with a golden 12-round permutation,
// plus a job-level scoreboard predicting grants, start, response timing and payload.
module tb_ascon_core_arbiter;
   import ascon_pkg::*;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 20;
   localparam int IDW     = $clog2(NREQ);

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [NREQ-1:0]        req_valid = '0;
   state_t [NREQ-1:0]      req_state = '0;
   logic [NREQ-1:0]        req_ready_o;
   logic                   rsp_valid_o;
   logic                   rsp_ready = 1'b0;
   logic [IDW-1:0]         rsp_id_o;
   state_t                 rsp_state_o;
   logic                   rsp_err_o;
   logic                   cfg_valid = 1'b0;
   logic [SBOX_ADDR_W-1:0] cfg_addr = '0;
   logic [SBOX_DATA_W-1:0] cfg_data = '0;
   logic                   cfg_ready_o;
   logic                   core_start_o;
   state_t                 core_state_o;
   logic                   core_upd_sbox_o;
   logic [SBOX_ADDR_W-1:0] core_sbox_addr_o;
   logic [SBOX_DATA_W-1:0] core_sbox_data_o;
   logic                   core_busy;
   state_t                 core_res;
   logic                   core_intr;
   logic                   suppress = 1'b0;

   ascon_core_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid_i      (req_valid),
      .req_state_i      (req_state),
      .req_ready_o      (req_ready_o),
      .rsp_valid_o      (rsp_valid_o),
      .rsp_ready_i      (rsp_ready),
      .rsp_id_o         (rsp_id_o),
      .rsp_state_o      (rsp_state_o),
      .rsp_err_o        (rsp_err_o),
      .cfg_valid_i      (cfg_valid),
      .cfg_addr_i       (cfg_addr),
      .cfg_data_i       (cfg_data),
      .cfg_ready_o      (cfg_ready_o),
      .core_start_o     (core_start_o),
      .core_state_o     (core_state_o),
      .core_upd_sbox_o  (core_upd_sbox_o),
      .core_sbox_addr_o (core_sbox_addr_o),
      .core_sbox_data_o (core_sbox_data_o),
      .core_busy_i      (core_busy),
      .core_state_i     (core_res),
      .core_intr_i      (core_intr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic state_t p12(input state_t s);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      state_t o;
      x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
      for (int r = 0; r < ASCON_ROUNDS; r++) begin
         x2 = x2 ^ {56'h0, 4'(15 - r), 4'(r)};
         x0 ^= x4; x4 ^= x3; x2 ^= x1;
         t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
         x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
         x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
         x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
         x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
         x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
         x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
         x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
      end
      o[0] = x0; o[1] = x1; o[2] = x2; o[3] = x3; o[4] = x4;
      return o;
   endfunction

   function automatic state_t rand_state();
      logic [319:0] v;
      for (int w = 0; w < 10; w++) v[w*32 +: 32] = $urandom;
      return state_t'(v);
   endfunction

   // Behavioural core: busy for 12 cycles after start, then a one-cycle done pulse.
   int core_k;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_busy <= 1'b0; core_intr <= 1'b0; core_k <= 0; core_res <= '0;
      end else begin
         core_intr <= 1'b0;
         if (core_start_o) begin
            core_busy <= 1'b1; core_k <= 0; core_res <= p12(core_state_o);
         end else if (core_busy) begin
            if (core_k == ASCON_ROUNDS - 1) begin
               core_busy <= 1'b0; core_intr <= !suppress;
            end else begin
               core_k <= core_k + 1;
            end
         end
      end
   end

   // Job-level reference: one job in flight, response due 15 cycles after accept
   // (or TIMEOUT+3 when the core never reports done), held until consumed.
   int     cyc = 0, rst_age = 0, m_t = 0, m_due = 0, m_id = 0, m_last = NREQ - 1;
   int     n_lut = 0, n_rsp = 0;
   bit     m_busy = 0, m_err = 0;
   state_t m_in, m_exp;
   int     obs_grants[$];
   int     obs_cycles[$];

   always @(negedge clk) begin
      int g;
      logic [NREQ-1:0] exp_rdy;
      cyc++;
      if (!rst_n) begin
         rst_age = 0; m_busy = 0; m_last = NREQ - 1;
      end else begin
         rst_age++;
         if (rst_age >= 2) begin
            if (req_ready_o != '0) begin
               for (int i = 0; i < NREQ; i++) if (req_ready_o[i]) g = i;
               obs_grants.push_back(g);
               obs_cycles.push_back(cyc);
            end
            if (m_busy) begin
               m_t++;
               check("req_ready_busy", req_ready_o, 0);
               check("cfg_ready_busy", cfg_ready_o, 0);
               check("sbox_upd_busy", core_upd_sbox_o, 0);
               check("core_start", core_start_o, m_t == 1);
               if (m_t == 1) check("core_state", core_state_o, m_in);
               check("rsp_valid", rsp_valid_o, m_t >= m_due);
               if (m_t >= m_due) begin
                  check("rsp_id", rsp_id_o, m_id);
                  check("rsp_state", rsp_state_o, m_exp);
                  check("rsp_err", rsp_err_o, m_err);
                  if (rsp_ready) begin m_busy = 0; n_rsp++; end
               end
            end else begin
               check("cfg_ready_idle", cfg_ready_o, 1);
               check("rsp_valid_idle", rsp_valid_o, 0);
               check("core_start_idle", core_start_o, 0);
               check("sbox_upd", core_upd_sbox_o, cfg_valid);
               if (cfg_valid) begin
                  check("sbox_addr", core_sbox_addr_o, cfg_addr);
                  check("sbox_data", core_sbox_data_o, cfg_data);
                  n_lut++;
               end
               g = -1;
               if (!cfg_valid) begin
                  for (int d = NREQ; d >= 1; d--)
                     if (req_valid[(m_last + d) % NREQ]) g = (m_last + d) % NREQ;
               end
               exp_rdy = '0;
               if (g >= 0) exp_rdy[g] = 1'b1;
               check("req_ready", req_ready_o, exp_rdy);
               if (g >= 0) begin
                  m_busy = 1; m_t = 0; m_id = g; m_last = g; m_in = req_state[g];
                  m_err  = suppress;
                  m_exp  = suppress ? state_t'('0) : p12(m_in);
                  m_due  = suppress ? TIMEOUT + 3 : 15;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_accept(input int budget);
      int n0, k;
      n0 = obs_grants.size(); k = 0;
      while (obs_grants.size() == n0 && k < budget) begin tick(); k++; end
      check("accept_budget", obs_grants.size() > n0, 1);
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while (m_busy && k < budget) begin tick(); k++; end
      check("idle_budget", m_busy, 0);
   endtask

   task automatic check_reset_outputs();
      check("rst_req_ready", req_ready_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rsp_id", rsp_id_o, 0);
      check("rst_rsp_state", rsp_state_o, 0);
      check("rst_rsp_err", rsp_err_o, 0);
      check("rst_cfg_ready", cfg_ready_o, 0);
      check("rst_core_start", core_start_o, 0);
      check("rst_core_state", core_state_o, 0);
      check("rst_sbox_upd", core_upd_sbox_o, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
      $fatal(1, "bench time limit");
   end

   initial begin
      int base, c0, l0, k;
      state_t iv;
      rst_n = 1'b0;
      tick(); tick();
      check_reset_outputs();
      rst_n = 1'b1;
      tick(); tick();

      // Fairness from reset: 0,1,2,3,0 at 16-cycle spacing.
      for (int i = 0; i < NREQ; i++) req_state[i] = rand_state();
      rsp_ready = 1'b1; req_valid = '1;
      base = obs_grants.size();
      repeat (5) wait_accept(40);
      req_valid = '0;
      wait_idle(40);
      for (int i = 0; i < 5; i++) check("fair_order", obs_grants[base + i], i % NREQ);
      for (int i = 1; i < 5; i++)
         check("fair_interval", obs_cycles[base + i] - obs_cycles[base + i - 1], 16);

      // Single job on requester 2 with the ASCON-128 IV word.
      iv = rand_state(); iv[0] = 64'h80400c0600000000;
      req_state[2] = iv; req_valid = 4'b0100;
      base = obs_grants.size();
      wait_accept(10);
      req_valid = '0;
      check("single_grant", obs_grants[base], 2);
      wait_idle(40);

      // Config priority over a pending request for three cycles.
      req_state[0] = rand_state();
      cfg_valid = 1'b1; req_valid = 4'b0001;
      l0 = n_lut; c0 = cyc + 1;
      base = obs_grants.size();
      repeat (3) begin
         cfg_addr = SBOX_ADDR_W'($urandom); cfg_data = SBOX_DATA_W'($urandom);
         tick();
      end
      cfg_valid = 1'b0;
      wait_accept(5);
      req_valid = '0;
      check("cfg_lut_writes", n_lut - l0, 3);
      check("cfg_grant_cycle", obs_cycles[base] - c0, 3);
      wait_idle(40);

      // Response backpressure with config and all requests pending.
      req_state[1] = rand_state(); req_valid = 4'b0010; rsp_ready = 1'b0;
      wait_accept(10);
      req_valid = '1; cfg_valid = 1'b1;
      k = 0;
      while (!rsp_valid_o && k < 40) begin tick(); k++; end
      check("bp_rsp_seen", rsp_valid_o, 1);
      base = obs_grants.size(); l0 = n_lut;
      repeat (10) tick();
      check("bp_no_grant", obs_grants.size(), base);
      check("bp_no_lut", n_lut, l0);
      req_valid = '0; cfg_valid = 1'b0; rsp_ready = 1'b1;
      wait_idle(10);

      // Watchdog abort when the core never signals done.
      suppress = 1'b1;
      req_state[3] = rand_state(); req_valid = 4'b1000;
      wait_accept(10);
      req_valid = '0;
      wait_idle(60);
      suppress = 1'b0;

      // Random traffic.
      repeat (1500) begin
         req_valid = NREQ'($urandom);
         for (int i = 0; i < NREQ; i++) req_state[i] = rand_state();
         cfg_valid = ($urandom_range(0, 7) == 0);
         cfg_addr  = SBOX_ADDR_W'($urandom);
         cfg_data  = SBOX_DATA_W'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = '0; cfg_valid = 1'b0; rsp_ready = 1'b1;
      wait_idle(60);

      // Async reset in the middle of a job drops it and restores the pointer.
      req_state[2] = rand_state(); req_valid = 4'b0100;
      wait_accept(10);
      req_valid = '0;
      k = 0;
      while (m_t < 7 && k < 20) begin tick(); k++; end
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      for (int i = 0; i < NREQ; i++) req_state[i] = rand_state();
      req_valid = '1;
      base = obs_grants.size();
      wait_accept(10);
      req_valid = '0;
      check("post_reset_grant", obs_grants[base], 0);
      wait_idle(40);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
